// File: rtl/pipeline_adder_pkg.sv
// pipeline_adder_pkg: shared defaults, ID sizing and the tag type for the
// adder arbiter. Tag ids are sized for the largest supported NREQ (16).
package pipeline_adder_pkg;
    localparam int DEF_WIDTH   = 64;
    localparam int DEF_ADD_LAT = 4;
    localparam int TAG_ID_W    = 4;

    function automatic int id_w(input int n);
        return $clog2(n);
    endfunction

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;
endpackage

// File: rtl/pipeline_adder_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant starting at ptr; ptr advances past the
// winner only when the grant is enabled.
module rr_arbiter
    import pipeline_adder_pkg::*;
#(
    parameter int  NREQ = 4,
    localparam int IW   = id_w(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   gnt_id
);
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW:0]   j;
    logic          found;

    always_comb begin
        gnt_id = '0;
        found  = 1'b0;
        j      = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = {1'b0, ptr_q} + (IW+1)'(k);
            j = (j >= (IW+1)'(NREQ)) ? j - (IW+1)'(NREQ) : j;
            if (!found && req[j[IW-1:0]]) begin
                found  = 1'b1;
                gnt_id = j[IW-1:0];
            end
        end
        grant = (en && found) ? NREQ'(1) << gnt_id : '0;
        ptr_d = (en && found) ? ((gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + 1'b1) : ptr_q;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
endmodule

// File: rtl/pipeline_adder_arbiter.sv
// pipeline_adder_arbiter: shares one fixed-latency adder among NREQ
// requesters, tracking requester ids alongside the adder pipeline.
module pipeline_adder_arbiter
    import pipeline_adder_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NREQ    = 4,
    parameter int ADD_LAT = DEF_ADD_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_cin,
    input  logic [WIDTH-1:0]      add_sum,
    input  logic                  add_cout,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  busy
);
    localparam int IW = id_w(NREQ);

    logic [NREQ-1:0]  grant;
    logic [IW-1:0]    gnt_id;
    logic             accept;
    logic [WIDTH-1:0] add_a_q, add_a_d, add_b_q, add_b_d, rsp_sum_q, rsp_sum_d;
    logic             add_cin_q, add_cin_d, rsp_cout_q, rsp_cout_d;
    logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
    tag_t             tag_q [ADD_LAT+1];
    tag_t             tag_d;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .req    (req_valid),
        .grant  (grant),
        .gnt_id (gnt_id)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    // Idle cycles feed zeros so the adder never sees stale operands.
    always_comb begin
        add_a_d     = accept ? req_a[gnt_id*WIDTH +: WIDTH] : '0;
        add_b_d     = accept ? req_b[gnt_id*WIDTH +: WIDTH] : '0;
        add_cin_d   = accept ? req_cin[gnt_id] : 1'b0;
        tag_d       = '{valid: accept, id: TAG_ID_W'(gnt_id)};
        rsp_valid_d = tag_q[ADD_LAT].valid ? NREQ'(1) << tag_q[ADD_LAT].id : '0;
        rsp_sum_d   = tag_q[ADD_LAT].valid ? add_sum : rsp_sum_q;
        rsp_cout_d  = tag_q[ADD_LAT].valid ? add_cout : rsp_cout_q;
        busy        = 1'b0;
        for (int s = 0; s <= ADD_LAT; s++) busy = busy | tag_q[s].valid;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            for (int s = 0; s <= ADD_LAT; s++) tag_q[s] <= '0;
        end else begin
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            tag_q[0]    <= tag_d;
            for (int s = 1; s <= ADD_LAT; s++) tag_q[s] <= tag_q[s-1];
        end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
endmodule

// File: tb/tb_pipeline_adder_arbiter.sv
// tb_pipeline_adder_arbiter: directed checks of arbitration, latency, drain
// and reset behaviour against a behavioural 4-cycle adder.
module tb_pipeline_adder_arbiter;
    localparam int W = 64;
    localparam int N = 4;
    localparam int L = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en  = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   req_cin = '0;
    logic [W-1:0]   add_a, add_b, add_sum, rsp_sum;
    logic           add_cin, add_cout, rsp_cout, busy;
    logic [N-1:0]   rsp_valid;

    pipeline_adder_arbiter #(.WIDTH(W), .NREQ(N), .ADD_LAT(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // External adder: result of operands seen in cycle t appears in cycle t+L.
    logic [W:0] pipe [L];
    always @(posedge clk) begin
        pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + (W+1)'(add_cin);
        for (int s = 1; s < L; s++) pipe[s] <= pipe[s-1];
    end
    assign add_sum  = pipe[L-1][W-1:0];
    assign add_cout = pipe[L-1][W];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [N-1:0] rv_q [$];
    logic [W:0]   rs_q [$];
    int           rc_q [$];
    always @(negedge clk)
        if (rsp_valid != '0) begin
            rv_q.push_back(rsp_valid);
            rs_q.push_back({rsp_cout, rsp_sum});
            rc_q.push_back(cyc);
        end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr;
        rv_q.delete();
        rs_q.delete();
        rc_q.delete();
    endtask

    // One-requester issue; returns the cycle count just after the accepting edge.
    task automatic send(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, output int c);
        logic [N-1:0] one = 1;
        req_valid = one << id;
        req_a = '0;
        req_b = '0;
        req_cin = '0;
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_cin[id] = cin;
        #1 chk("send_ready", req_ready, one << id);
        tick;
        c = cyc;
        req_valid = '0;
    endtask

    task automatic wait_rsp(input int n);
        for (int k = 0; k < 60 && rv_q.size() < n; k++) tick;
        chk("rsp_cnt", rv_q.size(), n);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        logic [N-1:0] one = 1;
        logic [W-1:0] ones = '1;
        req_valid = '1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_sum", {rsp_cout, rsp_sum}, 0);
        chk("rst_add", {add_cin, add_a, add_b}, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        req_valid = '0;
        en = 1'b1;
        tick;

        send(2, 5, 7, 1'b1, c);
        wait_rsp(1);
        chk("single_v", rv_q[0], 4'b0100);
        chk("single_s", rs_q[0], 13);
        chk("single_lat", rc_q[0] - c, L + 1);
        clr();

        send(1, ones, 0, 1'b1, c);
        send(1, 200, 0, 1'b0, c);
        wait_rsp(2);
        chk("wrap_v0", rv_q[0], 4'b0010);
        chk("wrap_s0", rs_q[0], {1'b1, 64'd0});
        chk("wrap_v1", rv_q[1], 4'b0010);
        chk("wrap_s1", rs_q[1], 200);
        clr();

        rst = 1'b1;
        tick;
        rst = 1'b0;
        req_valid = '1;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = 64'(1000 * (i + 1));
            req_b[i*W +: W] = 64'(i);
        end
        req_cin = '0;
        for (int k = 0; k < 8; k++) begin
            #1 chk("fair_gnt", req_ready, one << (k % N));
            tick;
        end
        req_valid = '0;
        wait_rsp(8);
        for (int k = 0; k < 8; k++) begin
            chk("fair_v", rv_q[k], one << (k % N));
            chk("fair_s", rs_q[k], 1000 * (k % N + 1) + k % N);
        end
        clr();

        for (int i = 0; i < 32; i++) send(0, 64'(i), 64'(200 + i), i[0], c);
        wait_rsp(32);
        for (int i = 0; i < 32; i++) begin
            chk("b2b_s", rs_q[i], 200 + 2 * i + (i % 2));
            chk("b2b_cyc", rc_q[i] - rc_q[0], i);
        end
        clr();

        send(0, 1, 2, 1'b0, c);
        send(1, 3, 4, 1'b0, c);
        send(2, 5, 6, 1'b1, c);
        en = 1'b0;
        req_valid = '1;
        for (int k = 1; k <= 6; k++) begin
            #1 chk("drain_ready", req_ready, 0);
            tick;
            chk("drain_busy", busy, k <= L);
        end
        wait_rsp(3);
        chk("drain_v0", rv_q[0], 4'b0001);
        chk("drain_s0", rs_q[0], 3);
        chk("drain_v1", rv_q[1], 4'b0010);
        chk("drain_s1", rs_q[1], 7);
        chk("drain_v2", rv_q[2], 4'b0100);
        chk("drain_s2", rs_q[2], 12);
        clr();
        req_valid = '0;
        en = 1'b1;

        send(0, 10, 10, 1'b0, c);
        send(1, 20, 20, 1'b0, c);
        send(2, 30, 30, 1'b0, c);
        rst = 1'b1;
        tick;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_sum", {rsp_cout, rsp_sum}, 0);
        chk("mid_rst_add", {add_cin, add_a, add_b}, 0);
        rst = 1'b0;
        repeat (10) tick;
        chk("mid_rst_norsp", rv_q.size(), 0);
        send(1, 33, 44, 1'b1, c);
        wait_rsp(1);
        chk("post_rst_v", rv_q[0], 4'b0010);
        chk("post_rst_s", rs_q[0], 78);
        chk("post_rst_lat", rc_q[0] - c, L + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
